// File: rtl/rename_sched.sv
// Rename-stage sequencer: dispatch gating on free registers, free-list return
// arbitration (commit over walk) and the mispredict-recovery walk of the ROB.
module rename_sched #(
    parameter int NUM_PHYS  = 32,
    parameter int PHYS_W    = 5,
    parameter int ARCH_W    = 5,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 disp_valid,
    input  logic [ARCH_W-1:0]    disp_arch_dest,
    output logic                 disp_ready,
    input  logic                 commit_valid,
    input  logic [PHYS_W-1:0]    commit_old_phys,
    input  logic                 flush_req,
    input  logic [ROB_IDX_W:0]   flush_cnt,
    input  logic [ROB_IDX_W-1:0] flush_tail_idx,
    output logic [ROB_IDX_W-1:0] walk_idx,
    input  logic                 walk_has_dest,
    input  logic [ARCH_W-1:0]    walk_arch_dest,
    input  logic [PHYS_W-1:0]    walk_new_phys,
    input  logic [PHYS_W-1:0]    walk_old_phys,
    output logic                 fl_assign,
    output logic                 fl_ret_valid,
    output logic [PHYS_W-1:0]    fl_ret_phys,
    output logic                 rat_restore_valid,
    output logic [ARCH_W-1:0]    rat_restore_arch,
    output logic [PHYS_W-1:0]    rat_restore_phys,
    output logic                 busy,
    output logic [PHYS_W:0]      free_cnt,
    output logic                 err_flush_overlap
);

    typedef enum logic {RUN, RECOVER} state_t;

    localparam logic [PHYS_W:0]    FREE_MAX = (PHYS_W+1)'(NUM_PHYS - 1);
    localparam logic [ROB_IDX_W:0] REM_ONE  = (ROB_IDX_W+1)'(1);

    state_t               state;
    logic [ROB_IDX_W:0]   rem;
    logic                 recover;
    logic                 walk_consume;
    logic                 walk_ret;

    // A walk entry with a destination needs the return port, so it waits out a commit.
    assign recover      = (state == RECOVER);
    assign walk_ret     = recover && walk_has_dest && !commit_valid;
    assign walk_consume = recover && !(walk_has_dest && commit_valid);

    assign disp_ready        = !recover && !flush_req && (free_cnt != '0 || disp_arch_dest == '0);
    assign fl_assign         = disp_valid && disp_ready && (disp_arch_dest != '0);
    assign fl_ret_valid      = commit_valid || walk_ret;
    assign fl_ret_phys       = commit_valid ? commit_old_phys : walk_new_phys;
    assign rat_restore_valid = walk_ret;
    assign rat_restore_arch  = walk_arch_dest;
    assign rat_restore_phys  = walk_old_phys;
    assign busy              = recover;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= RUN;
            walk_idx          <= '0;
            rem               <= '0;
            free_cnt          <= FREE_MAX;
            err_flush_overlap <= 1'b0;
        end else begin
            free_cnt <= free_cnt - {{PHYS_W{1'b0}}, fl_assign} + {{PHYS_W{1'b0}}, fl_ret_valid};
            case (state)
                RUN: begin
                    if (flush_req && flush_cnt != '0) begin
                        state    <= RECOVER;
                        walk_idx <= flush_tail_idx;
                        rem      <= flush_cnt;
                    end
                end
                RECOVER: begin
                    if (flush_req) begin
                        err_flush_overlap <= 1'b1;
                    end
                    // Walk goes youngest to oldest, wrapping through index 0.
                    if (walk_consume) begin
                        walk_idx <= walk_idx - 1'b1;
                        rem      <= rem - 1'b1;
                        if (rem == REM_ONE) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (free_cnt <= FREE_MAX);
        end
    end

endmodule

// File: tb/tb_rename_sched.sv
// Randomized + directed bench for rename_sched: a behavioural model pushes the
// expected per-cycle status and port events into queues that a monitor drains.
module tb_rename_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       disp_valid;
    logic [4:0] disp_arch_dest;
    logic       disp_ready;
    logic       commit_valid;
    logic [4:0] commit_old_phys;
    logic       flush_req;
    logic [4:0] flush_cnt;
    logic [3:0] flush_tail_idx;
    logic [3:0] walk_idx;
    logic       walk_has_dest;
    logic [4:0] walk_arch_dest;
    logic [4:0] walk_new_phys;
    logic [4:0] walk_old_phys;
    logic       fl_assign;
    logic       fl_ret_valid;
    logic [4:0] fl_ret_phys;
    logic       rat_restore_valid;
    logic [4:0] rat_restore_arch;
    logic [4:0] rat_restore_phys;
    logic       busy;
    logic [5:0] free_cnt;
    logic       err_flush_overlap;

    rename_sched dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_arch_dest(disp_arch_dest), .disp_ready(disp_ready),
        .commit_valid(commit_valid), .commit_old_phys(commit_old_phys),
        .flush_req(flush_req), .flush_cnt(flush_cnt), .flush_tail_idx(flush_tail_idx),
        .walk_idx(walk_idx), .walk_has_dest(walk_has_dest), .walk_arch_dest(walk_arch_dest),
        .walk_new_phys(walk_new_phys), .walk_old_phys(walk_old_phys),
        .fl_assign(fl_assign), .fl_ret_valid(fl_ret_valid), .fl_ret_phys(fl_ret_phys),
        .rat_restore_valid(rat_restore_valid), .rat_restore_arch(rat_restore_arch),
        .rat_restore_phys(rat_restore_phys), .busy(busy), .free_cnt(free_cnt),
        .err_flush_overlap(err_flush_overlap)
    );

    always #5 clk = ~clk;

    // ROB contents seen by the walk; the ROB answers combinationally on walk_idx.
    bit       rob_has_dest [16];
    bit [4:0] rob_arch [16];
    bit [4:0] rob_new [16];
    bit [4:0] rob_old [16];

    assign walk_has_dest  = rob_has_dest[walk_idx];
    assign walk_arch_dest = rob_arch[walk_idx];
    assign walk_new_phys  = rob_new[walk_idx];
    assign walk_old_phys  = rob_old[walk_idx];

    typedef struct {
        bit ready, assign_, ret_v, rat_v, busy, err;
        int free, widx;
    } status_t;

    typedef struct {
        int arch, phys;
    } restore_t;

    status_t  status_q[$];
    int       ret_q[$];
    restore_t restore_q[$];

    int compared = 0;
    int mismatched = 0;
    bit checking = 0;

    // Reference model state: counts and positions, not the DUT's encoding.
    bit m_busy, m_err;
    int m_free, m_pos, m_rem, m_pend;

    task automatic check_output(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (status_q.size() > 0) begin
                status_t s;
                s = status_q.pop_front();
                check_output("disp_ready", int'(disp_ready), int'(s.ready));
                check_output("fl_assign", int'(fl_assign), int'(s.assign_));
                check_output("fl_ret_valid", int'(fl_ret_valid), int'(s.ret_v));
                check_output("rat_restore_valid", int'(rat_restore_valid), int'(s.rat_v));
                check_output("busy", int'(busy), int'(s.busy));
                check_output("err_flush_overlap", int'(err_flush_overlap), int'(s.err));
                check_output("free_cnt", int'(free_cnt), s.free);
                check_output("walk_idx", int'(walk_idx), s.widx);
            end
            if (fl_ret_valid) begin
                if (ret_q.size() == 0) check_output("ret_unexpected", 1, 0);
                else check_output("fl_ret_phys", int'(fl_ret_phys), ret_q.pop_front());
            end
            if (rat_restore_valid) begin
                if (restore_q.size() == 0) check_output("restore_unexpected", 1, 0);
                else begin
                    restore_t r;
                    r = restore_q.pop_front();
                    check_output("rat_restore_arch", int'(rat_restore_arch), r.arch);
                    check_output("rat_restore_phys", int'(rat_restore_phys), r.phys);
                end
            end
        end
    end

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_free = 31; m_pos = 0; m_rem = 0; m_pend = 0;
    endtask

    task automatic do_reset(input int cycles);
        checking = 0;
        reset = 1;
        disp_valid = 0; disp_arch_dest = 0; commit_valid = 0; commit_old_phys = 0;
        flush_req = 0; flush_cnt = 0; flush_tail_idx = 0;
        repeat (cycles) begin @(posedge clk); #1; end
        reset = 0;
        model_reset();
        checking = 1;
    endtask

    // Fill the squashed range; destinations beyond the free-list headroom are dropped.
    task automatic load_rob(input int tail, input int cnt, input int budget, input bit all_dest);
        int used = 0;
        for (int k = 0; k < cnt; k++) begin
            int i = (tail - k + 16) % 16;
            rob_has_dest[i] = all_dest ? 1'b1 : 1'($urandom_range(0, 1));
            if (rob_has_dest[i] && used >= budget) rob_has_dest[i] = 0;
            if (rob_has_dest[i]) used++;
            rob_arch[i] = 5'($urandom_range(1, 31));
            rob_new[i]  = 5'($urandom_range(1, 31));
            rob_old[i]  = 5'($urandom_range(1, 31));
        end
    endtask

    task automatic apply_stimulus(input bit dv, input int dest, input bit cv, input int cold,
                                  input bit fr, input int fcnt, input int ftail);
        status_t s;
        bit hd, walk_ret, consume;
        disp_valid = dv; disp_arch_dest = 5'(dest);
        commit_valid = cv; commit_old_phys = 5'(cold);
        flush_req = fr; flush_cnt = 5'(fcnt); flush_tail_idx = 4'(ftail);

        hd = m_busy && rob_has_dest[m_pos];
        walk_ret = hd && !cv;
        consume = m_busy && !(hd && cv);
        s.ready   = !m_busy && !fr && (m_free > 0 || dest == 0);
        s.assign_ = dv && s.ready && dest != 0;
        s.ret_v   = cv || walk_ret;
        s.rat_v   = walk_ret;
        s.busy    = m_busy;
        s.err     = m_err;
        s.free    = m_free;
        s.widx    = m_pos;
        status_q.push_back(s);
        if (cv) ret_q.push_back(cold);
        else if (walk_ret) ret_q.push_back(int'(rob_new[m_pos]));
        if (walk_ret) restore_q.push_back('{int'(rob_arch[m_pos]), int'(rob_old[m_pos])});

        m_free = m_free + int'(s.ret_v) - int'(s.assign_);
        if (m_busy) begin
            if (fr) m_err = 1;
            if (walk_ret) m_pend--;
            if (consume) begin
                m_pos = (m_pos + 15) % 16;
                m_rem--;
                if (m_rem == 0) m_busy = 0;
            end
        end else if (fr && fcnt != 0) begin
            m_busy = 1; m_pos = ftail; m_rem = fcnt; m_pend = 0;
            for (int k = 0; k < fcnt; k++) if (rob_has_dest[(ftail - k + 16) % 16]) m_pend++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset(2);
        idle(1);

        // Exhaust the free list, then confirm x0 still dispatches without allocating.
        repeat (31) apply_stimulus(1, 3, 0, 0, 0, 0, 0);
        apply_stimulus(1, 3, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, 10 + i, 0, 0, 0);
        apply_stimulus(1, 7, 1, 9, 0, 0, 0);

        // Three-entry walk wrapping 1,0,15, then the same walk with a commit stall.
        load_rob(1, 3, 3, 1);
        apply_stimulus(0, 0, 0, 0, 1, 3, 1);
        idle(4);
        load_rob(1, 3, 3, 1);
        apply_stimulus(0, 0, 0, 0, 1, 3, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 4, 1, 20, 0, 0, 0);
        idle(4);

        // Overlapping flush sets the sticky error; reset mid-walk clears everything.
        load_rob(5, 3, 3, 1);
        apply_stimulus(0, 0, 0, 0, 1, 3, 5);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 2, 9);
        idle(3);
        load_rob(12, 6, 6, 1);
        apply_stimulus(0, 0, 0, 0, 1, 6, 12);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        do_reset(1);
        idle(1);

        for (int n = 0; n < 4000; n++) begin
            bit dv, cv, fr, rdy, a;
            int dest, fcnt, ftail;
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
                continue;
            end
            dv = 1'($urandom_range(0, 3) != 0);
            dest = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            fr = m_busy ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 14) == 0);
            fcnt = int'($urandom_range(0, 16));
            ftail = int'($urandom_range(0, 15));
            rdy = !m_busy && !fr && (m_free > 0 || dest == 0);
            a = dv && rdy && dest != 0;
            cv = 1'($urandom_range(0, 2) == 0) && (m_free - int'(a) + 1 + m_pend <= 31);
            if (!m_busy && fr) load_rob(ftail, fcnt, 31 - m_free - int'(cv), 0);
            apply_stimulus(dv, dest, cv, int'($urandom_range(1, 31)), fr, fcnt, ftail);
        end
        idle(20);
        @(negedge clk); #1;
        checking = 0;
        check_output("status_q_drained", status_q.size(), 0);
        check_output("ret_q_drained", ret_q.size(), 0);
        check_output("restore_q_drained", restore_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
